dilithium_reduction_top: RTL and testbench
==========================================

# dilithium_reduction_top

Sequential modular-reduction block for the Dilithium prime q = 8380417 = 2^23 − 2^13 + 1. It reduces a DATA_LENGTH-bit unsigned operand to x mod q using only shifts and adds: precomputed folding 2^23 ≡ 2^13 − 1 (mod q), followed by conditional subtraction. It is the top-level reduction wrapper used in the Dilithium shift-add datapath and is driven by a one-cycle start pulse.

## Interface
- DATA_LENGTH, 64 (from params_pkg): operand/result width.
- Q, 8380417: hardwired modulus used for the folding constants.
- CLK_pci_sys_clk_p  in  1  system clock; rising-edge active.
- rst_ni  in  1  reset; one clock; reset is synchronous and active-high (port name kept for codebase compatibility; asserted = 1).
- start_i  in  1  start pulse; sampled on the rising edge.
- x_i  in  DATA_LENGTH  operand to reduce; unsigned.
- m_i  in  DATA_LENGTH  modulus; must equal Q; latched at start and used for the final correction.
- result_o  out  DATA_LENGTH  x mod m, zero-extended.
- valid_o  out  1  result valid; held high until the next accepted start.

## Operation
- FSM states: IDLE, FOLD, CORRECT, DONE.
- IDLE: on start_i=1, latch v ← x_i and mreg ← m_i; go to FOLD.
- FOLD: one fold per cycle while v ≥ 2^24: v ← v[DATA_LENGTH-1:23]·(2^13 − 1) + v[22:0].
  - The multiply is implemented as (hi<<13) − hi; no multiplier.
  - When v < 2^24, go to CORRECT.
- CORRECT: one step per cycle: if v ≥ mreg then v ← v − mreg, else go to DONE.
  - Since v < 2^24 < 3q, at most 2 subtractions occur.
- DONE: result_o ← v[22:0] zero-extended; valid_o = 1. Stay in DONE with the result stable.
- From DONE, start_i=1 starts a new operation: clear valid_o, latch the new operands, go to FOLD.
- Width rules:
  - Internal accumulator is DATA_LENGTH+1 bits, so fold sums cannot overflow.
  - All arithmetic is unsigned.
  - result_o is always < m when m_i = Q.
- m_i ≠ Q is unsupported. The handshake still completes, but result_o is unspecified.
- x_i = 0 is legal and produces 0.

## Timing
- Reset (rst_ni=1 at a rising edge): state = IDLE, valid_o = 0, result_o = 0, internal registers cleared.
- Reset takes priority over start_i.
- Reset asserted mid-operation aborts the operation; the next cycle shows valid_o = 0 and result_o = 0.
- Latency from the start edge to valid_o high: 1 (load) + F folds + C corrections + 1 (DONE).
  - For DATA_LENGTH = 64: F ≤ 5 and C ≤ 3, including the final compare step.
  - Total latency ≤ 10 cycles.
- start_i while in FOLD or CORRECT is ignored; the operands in flight are unaffected.
- result_o and valid_o are registered. They change only on clock edges and are stable while valid_o = 1.
- valid_o falls on the edge that accepts the next start.
- x_i and m_i need only be stable at the accepting edge.

## Test plan
- Reset: hold rst_ni=1 for 4 cycles, then release -> valid_o = 0 and result_o = 0; no activity without start.
- Small values: x = 8380416 -> 8380416; x = 8380417 -> 0; x = 0 -> 0. valid_o rises within 10 cycles each time and stays high.
- Single fold plus correction: x = 8388608 (2^23) -> 8191; x = 16760839 (2q + 5) -> 5.
- Max operand: x = 0xFFFFFFFFFFFFFFFF -> 0x2419FE (2365950). Latency ≤ 10 cycles.
- Back-to-back: 100 random 64-bit x, each started one cycle after valid_o is seen -> every result equals x % 8380417. valid_o drops on each new start.
- Abort and ignore:
  - Assert reset mid-FOLD -> outputs return to 0; a subsequent start computes correctly.
  - Pulse start during CORRECT -> it is ignored, and the first result is delivered unchanged.

Source files
------------

// File: rtl/dilithium_reduction_top.sv
// Shift-add reduction of a DATA_LENGTH-bit operand modulo the Dilithium prime
// q = 2^23 - 2^13 + 1. It folds with 2^23 == 2^13 - 1 (mod q) and then applies
// at most two conditional subtractions of the latched modulus.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for the first start pulse, outputs cleared
// FOLD    | folding the accumulator while it is >= 2^24
// CORRECT | subtracting mreg while v >= mreg (bounded to two steps)
// DONE    | result_o holds v mod m, valid_o high until the next start
module dilithium_reduction_top #(
  parameter int unsigned DATA_LENGTH = 64
) (
  input  logic                   CLK_pci_sys_clk_p,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  output logic [DATA_LENGTH-1:0] result_o,
  output logic                   valid_o
);

  localparam int unsigned Q       = 32'd8380417;
  localparam int unsigned LO_BITS = 23;
  // 2^23 - q = 2^13 - 1, so the fold multiplier is (1 << FOLD_SH) - 1.
  localparam int unsigned FOLD_SH = $clog2((32'd1 << LO_BITS) - Q + 1);
  // One spare bit keeps fold sums and the unsigned compare free of overflow.
  localparam int unsigned ACC_W   = DATA_LENGTH + 1;
  localparam int unsigned HI_W    = ACC_W - LO_BITS;

  typedef enum logic [1:0] {
    IDLE,
    FOLD,
    CORRECT,
    DONE
  } state_t;

  state_t                 state;
  logic [ACC_W-1:0]       v_q;
  logic [DATA_LENGTH-1:0] m_q;
  logic [1:0]             corr_cnt;

  logic [ACC_W-1:0]       hi_ext;
  logic [ACC_W-1:0]       lo_ext;
  logic [ACC_W-1:0]       fold_sum;
  logic [ACC_W-1:0]       m_ext;
  logic                   v_big;
  logic                   fold_big;
  logic                   v_ge_m;

  // Fold datapath: hi * (2^13 - 1) + lo built from one shift and one subtract.
  always_comb begin
    hi_ext   = {{LO_BITS{1'b0}}, v_q[ACC_W-1:LO_BITS]};
    lo_ext   = {{HI_W{1'b0}}, v_q[LO_BITS-1:0]};
    fold_sum = (hi_ext << FOLD_SH) - hi_ext + lo_ext;
    m_ext    = {1'b0, m_q};
    v_big    = |v_q[ACC_W-1:LO_BITS+1];
    fold_big = |fold_sum[ACC_W-1:LO_BITS+1];
    v_ge_m   = (v_q >= m_ext);
  end

  // Sequencer with registered result/valid; reset wins over everything.
  always_ff @(posedge CLK_pci_sys_clk_p) begin
    if (rst_ni) begin
      state    <= IDLE;
      v_q      <= '0;
      m_q      <= '0;
      corr_cnt <= '0;
      result_o <= '0;
      valid_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            v_q   <= {1'b0, x_i};
            m_q   <= m_i;
            state <= FOLD;
          end
        end
        FOLD: begin
          // The correction budget is two subtractions; it also keeps an
          // unsupported modulus (e.g. zero) from stalling the handshake.
          corr_cnt <= 2'd2;
          if (v_big) begin
            v_q <= fold_sum;
            if (!fold_big) begin
              state <= CORRECT;
            end
          end else begin
            state <= CORRECT;
          end
        end
        CORRECT: begin
          if (v_ge_m && (corr_cnt != 2'd0)) begin
            v_q      <= v_q - m_ext;
            corr_cnt <= corr_cnt - 2'd1;
          end else begin
            result_o <= {{(DATA_LENGTH-LO_BITS){1'b0}}, v_q[LO_BITS-1:0]};
            valid_o  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          if (start_i) begin
            valid_o <= 1'b0;
            v_q     <= {1'b0, x_i};
            m_q     <= m_i;
            state   <= FOLD;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dilithium_reduction_top.sv
// Self-checking bench for dilithium_reduction_top; expected results come from
// plain x % q arithmetic in the bench.
module tb_dilithium_reduction_top;

  localparam logic [63:0] QV      = 64'd8380417;
  localparam int          MAX_LAT = 10;
  localparam int          TIMEOUT = 30;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] x;
  logic [63:0] m;
  logic [63:0] result;
  logic        valid;

  int pass_cnt = 0;
  int total    = 0;

  dilithium_reduction_top #(.DATA_LENGTH(64)) dut (
    .CLK_pci_sys_clk_p(clk),
    .rst_ni           (rst),
    .start_i          (start),
    .x_i              (x),
    .m_i              (m),
    .result_o         (result),
    .valid_o          (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mod(input logic [63:0] a);
    return a % QV;
  endfunction

  // Drive one start pulse; returns just after the accepting edge.
  task automatic start_op(input logic [63:0] xv);
    @(negedge clk);
    x     = xv;
    m     = QV;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x     = $urandom;
  endtask

  // Wait for valid; lat = edges after the accepting edge, -1 on timeout.
  task automatic wait_valid(output int lat);
    int n = 0;
    while (!valid && n < TIMEOUT) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = valid ? n : -1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    x     = '0;
    m     = QV;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", valid); else pass_cnt++;
    total++;
    if (result !== 64'd0) $display("FAIL reset_result got=%0d exp=0", result); else pass_cnt++;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (valid !== 1'b0 || result !== 64'd0)
      $display("FAIL idle_no_activity got valid=%0b result=%0d exp valid=0 result=0", valid, result);
    else pass_cnt++;
  endtask

  task automatic test_small();
    logic [63:0] vals[3] = '{64'd8380416, 64'd8380417, 64'd0};
    int lat;
    for (int i = 0; i < 3; i++) begin
      start_op(vals[i]);
      wait_valid(lat);
      total++;
      if (lat < 0 || lat > MAX_LAT) $display("FAIL small_latency x=%0d got=%0d exp<=%0d", vals[i], lat, MAX_LAT);
      else pass_cnt++;
      total++;
      if (result !== ref_mod(vals[i])) $display("FAIL small_result x=%0d got=%0d exp=%0d", vals[i], result, ref_mod(vals[i]));
      else pass_cnt++;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (valid !== 1'b1 || result !== ref_mod(vals[i]))
        $display("FAIL small_hold x=%0d got valid=%0b result=%0d exp valid=1 result=%0d", vals[i], valid, result, ref_mod(vals[i]));
      else pass_cnt++;
    end
  endtask

  task automatic test_fold();
    logic [63:0] vals[2] = '{64'd8388608, 64'd16760839};
    logic [63:0] exps[2] = '{64'd8191, 64'd5};
    int lat;
    for (int i = 0; i < 2; i++) begin
      start_op(vals[i]);
      wait_valid(lat);
      total++;
      if (lat < 0 || lat > MAX_LAT) $display("FAIL fold_latency x=%0d got=%0d exp<=%0d", vals[i], lat, MAX_LAT);
      else pass_cnt++;
      total++;
      if (result !== exps[i] || result !== ref_mod(vals[i]))
        $display("FAIL fold_result x=%0d got=%0d exp=%0d", vals[i], result, exps[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_max();
    int lat;
    start_op(64'hFFFF_FFFF_FFFF_FFFF);
    wait_valid(lat);
    total++;
    if (lat < 0 || lat > MAX_LAT) $display("FAIL max_latency got=%0d exp<=%0d", lat, MAX_LAT);
    else pass_cnt++;
    total++;
    if (result !== 64'd2365950) $display("FAIL max_result got=%0d exp=2365950", result);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] xv;
    int lat;
    for (int i = 0; i < 100; i++) begin
      case (i % 4)
        0: xv = {$urandom, $urandom};
        1: xv = {32'd0, $urandom};
        2: xv = {40'd0, 24'($urandom)};
        default: xv = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      endcase
      start_op(xv);
      total++;
      if (valid !== 1'b0) $display("FAIL b2b_valid_drop i=%0d got=%0b exp=0", i, valid);
      else pass_cnt++;
      wait_valid(lat);
      total++;
      if (lat < 0 || lat > MAX_LAT || result !== ref_mod(xv))
        $display("FAIL b2b_result i=%0d x=%0h got=%0d lat=%0d exp=%0d lat<=%0d", i, xv, result, lat, ref_mod(xv), MAX_LAT);
      else pass_cnt++;
    end
  endtask

  task automatic test_abort_fold();
    logic [63:0] xv = 64'hDEAD_BEEF_1234_5678;
    int lat;
    start_op(64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (valid !== 1'b0 || result !== 64'd0)
      $display("FAIL abort_outputs got valid=%0b result=%0d exp valid=0 result=0", valid, result);
    else pass_cnt++;
    repeat (12) @(posedge clk);
    #1;
    total++;
    if (valid !== 1'b0) $display("FAIL abort_stays_idle got=%0b exp=0", valid);
    else pass_cnt++;
    start_op(xv);
    wait_valid(lat);
    total++;
    if (lat < 0 || result !== ref_mod(xv))
      $display("FAIL abort_restart got=%0d lat=%0d exp=%0d", result, lat, ref_mod(xv));
    else pass_cnt++;
  endtask

  task automatic test_ignore_start();
    logic [63:0] xv = 64'd16760839;
    int lat;
    start_op(xv);
    @(posedge clk);
    @(negedge clk);
    x     = 64'hFFFF_FFFF_FFFF_FFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    x     = '0;
    wait_valid(lat);
    total++;
    if (lat < 0 || result !== 64'd5)
      $display("FAIL ignore_result got=%0d lat=%0d exp=5", result, lat);
    else pass_cnt++;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (valid !== 1'b1 || result !== 64'd5)
      $display("FAIL ignore_hold got valid=%0b result=%0d exp valid=1 result=5", valid, result);
    else pass_cnt++;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    x     = '0;
    m     = QV;
    test_reset();
    test_small();
    test_fold();
    test_max();
    test_back_to_back();
    test_abort_fold();
    test_ignore_start();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
